// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch_ctrl: in-order fetch sequencer with credit flow control,         |
// | response FIFO and redirect flush.                        Rev 1.0           |
// +----------------------------------------------------------------------------+
module ifu_fetch_ctrl #(
  parameter int XLEN                 = 32,
  parameter int INSTR_LEN            = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [XLEN-1:0]                 reset_vector,
  input  logic                            redirect_valid,
  input  logic [XLEN-1:0]                 redirect_pc,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr,
  output logic                            instr_mem_addr_valid,
  output logic [XLEN-1:0]                 instr_mem_tag_out,
  input  logic [INSTR_LEN-1:0]            instr_mem_rdata,
  input  logic                            instr_mem_rdata_valid,
  input  logic [XLEN-1:0]                 instr_mem_tag_in,
  input  logic                            pipe_stall,
  output logic [INSTR_LEN-1:0]            instr,
  output logic                            instr_valid,
  output logic [XLEN-1:0]                 instr_tag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [INSTR_LEN-1:0] data_q [FIFO_DEPTH];
  logic [XLEN-1:0]      tag_q  [FIFO_DEPTH];

  logic          resp_live;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  always_comb begin
    // Responses arriving with nothing in flight are leftovers from before a reset.
    resp_live  = instr_mem_rdata_valid && (inflight_q != '0);
    occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
    issue      = (state_q == ST_RUN) && !redirect_valid && (occupancy < CREDITS);
    push       = resp_live && (drop_q == '0) && !redirect_valid;
    pop        = (count_q != '0) && !pipe_stall;

    state_d    = ST_RUN;
    pc_d       = pc_q;
    inflight_d = inflight_q - CW'(resp_live) + CW'(issue);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (redirect_valid) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d   = inflight_q - CW'(resp_live);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (state_q == ST_BOOT) begin
        pc_d = reset_vector;
      end else if (issue) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (resp_live && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= instr_mem_rdata;
      tag_q[wr_ptr_q]  <= instr_mem_tag_in;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

  assign instr_mem_addr       = pc_q[INSTR_MEM_ADDR_WIDTH-1:0];
  assign instr_mem_addr_valid = issue;
  assign instr_mem_tag_out    = pc_q;
  assign instr_valid          = (count_q != '0);
  assign instr                = instr_valid ? data_q[rd_ptr_q] : '0;
  assign instr_tag            = instr_valid ? tag_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifu_fetch_ctrl: random/directed scoreboard bench for ifu_fetch_ctrl.    |
// |                                                          Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_ifu_fetch_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reset_vector;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] instr_mem_addr;
  logic        instr_mem_addr_valid;
  logic [31:0] instr_mem_tag_out;
  logic [31:0] instr_mem_rdata;
  logic        instr_mem_rdata_valid;
  logic [31:0] instr_mem_tag_in;
  logic        pipe_stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_tag;

  ifu_fetch_ctrl #(.XLEN(32), .INSTR_LEN(32), .INSTR_MEM_ADDR_WIDTH(16), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .reset_vector(reset_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_mem_addr(instr_mem_addr), .instr_mem_addr_valid(instr_mem_addr_valid),
    .instr_mem_tag_out(instr_mem_tag_out), .instr_mem_rdata(instr_mem_rdata),
    .instr_mem_rdata_valid(instr_mem_rdata_valid), .instr_mem_tag_in(instr_mem_tag_in),
    .pipe_stall(pipe_stall), .instr(instr), .instr_valid(instr_valid), .instr_tag(instr_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tag;
    int          due;
    bit          live;
    int          ep;
  } req_t;

  req_t        pend[$];      // memory model: requests not yet answered
  logic [31:0] exp_q[$];     // live program-order PCs still owed to decode
  logic [31:0] pop_hist[$];  // every tag decode consumed
  int total = 0, bad = 0;
  int cyc = 0, ep = 0, lat_lo = 1, lat_hi = 1;
  int m_fifo = 0, n_pop = 0;
  bit m_boot = 1'b1, popped = 1'b0;
  bit r_fire = 1'b0, r_live = 1'b0;
  int r_ep = 0;
  logic [31:0] m_pc = '0;

  function automatic logic [31:0] mdata(input logic [31:0] t);
    return {t[15:0], t[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic int cred_now();
    int c = 0;
    foreach (pend[i]) if (pend[i].ep == ep) c++;
    return c;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic drive_mem();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      instr_mem_rdata_valid = 1'b1;
      instr_mem_tag_in      = pend[0].tag;
      instr_mem_rdata       = mdata(pend[0].tag);
      r_fire = 1'b1;
      r_live = pend[0].live;
      r_ep   = pend[0].ep;
      void'(pend.pop_front());
    end else begin
      instr_mem_rdata_valid = 1'b0;
      instr_mem_tag_in      = $urandom;
      instr_mem_rdata       = $urandom;
      r_fire = 1'b0;
    end
  endtask

  task automatic tick(input bit rv, input logic [31:0] rp, input bit st);
    @(posedge clk); cyc++; #1;
    redirect_valid = rv;
    redirect_pc    = rp;
    pipe_stall     = st;
    drive_mem();
  endtask

  task automatic tick_rof(input logic [31:0] rp, output bit fired);
    @(posedge clk); cyc++; #1;
    pipe_stall = 1'b0;
    drive_mem();
    redirect_valid = r_fire;
    redirect_pc    = rp;
    fired          = r_fire;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_addr_valid"}, instr_mem_addr_valid, 0);
    check({pfx, "_addr"}, instr_mem_addr, 0);
    check({pfx, "_tag_out"}, instr_mem_tag_out, 0);
    check({pfx, "_instr_valid"}, instr_valid, 0);
    check({pfx, "_instr"}, instr, 0);
    check({pfx, "_instr_tag"}, instr_tag, 0);
  endtask

  task automatic settle_mark(output int p);
    @(negedge clk); #2;
    p = pop_hist.size();
  endtask

  task automatic wait_pop(input int p, input string nm, input logic [31:0] want);
    for (int i = 0; i < 40 && pop_hist.size() <= p; i++) begin
      tick(0, '0, 0);
      @(negedge clk); #2;
    end
    if (pop_hist.size() > p) check(nm, pop_hist[p], want);
    else begin
      total++; bad++;
      $display("FAIL %s: no delivery within bound, want %0h", nm, want);
    end
  endtask

  // Reference: every live request is owed to decode in issue order; credits are
  // requests issued since reset that have not answered plus entries buffered.
  task automatic model_step();
    int  cred;
    bit  ei;
    cred = cred_now() + ((r_fire && r_ep == ep) ? 1 : 0);
    ei   = !m_boot && !redirect_valid && (cred + m_fifo < D);
    check("issue", instr_mem_addr_valid, ei);
    check("instr_valid", instr_valid, m_fifo != 0);
    if (instr_mem_addr_valid) begin
      check("req_tag", instr_mem_tag_out, m_pc);
      check("req_addr", instr_mem_addr, m_pc[15:0]);
      pend.push_back('{tag: m_pc, due: cyc + int'($urandom_range(lat_hi, lat_lo)), live: 1'b1, ep: ep});
      exp_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (r_fire && r_live && r_ep == ep && !redirect_valid) m_fifo++;
    if (popped) m_fifo--;
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'd3;
      exp_q.delete();
      foreach (pend[i]) pend[i].live = 1'b0;
      m_fifo = 0;
    end
    if (m_boot) begin
      if (!redirect_valid) m_pc = reset_vector;
      m_boot = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL deliver: unexpected tag %0h, none owed", instr_tag);
      end else begin
        check("head_tag", instr_tag, exp_q[0]);
        check("head_data", instr, mdata(exp_q[0]));
      end
      if (!pipe_stall) begin
        pop_hist.push_back(instr_tag);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        popped = 1'b1;
        n_pop++;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) model_step();
    popped = 1'b0;
  end

  task automatic mid_reset();
    @(posedge clk); cyc++; #1;
    redirect_valid = 1'b0;
    pipe_stall     = 1'b0;
    drive_mem();
    #2;
    rst_n  = 1'b0;
    ep++;
    m_boot = 1'b1;
    m_fifo = 0;
    exp_q.delete();
    foreach (pend[i]) pend[i].live = 1'b0;
    #1;
    check_zero("midrst");
    for (int i = 0; i < 20 && pend.size() > 0; i++) tick(0, '0, 0);
    if (pend.size() > 0) begin
      total++; bad++;
      $display("FAIL midrst_drain: %0d responses still pending, want 0", pend.size());
    end
    @(posedge clk); cyc++; #1;
    pend.push_back('{tag: 32'hDEAD_BEE0, due: cyc, live: 1'b0, ep: -1});
    drive_mem();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int  p, p0;
    bit  fired;
    rst_n          = 1'b0;
    reset_vector   = 32'h8000_0000;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pipe_stall     = 1'b0;
    instr_mem_rdata_valid = 1'b0;
    instr_mem_rdata  = '0;
    instr_mem_tag_in = '0;
    #3;
    check_zero("rst");
    repeat (3) tick(0, '0, 0);
    rst_n = 1'b1;

    // Boot, latency 1, free running
    settle_mark(p);
    wait_pop(p, "t1_first", 32'h8000_0000);
    repeat (15) tick(0, '0, 0);

    // Long stall with latency 2: credits exhaust, then drain 4 in 4 cycles
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 10; i++) begin
      tick(0, '0, 1);
      if (i >= 7) check("t2_stall_no_issue", instr_mem_addr_valid, 0);
    end
    p0 = n_pop;
    repeat (4) tick(0, '0, 0);
    @(negedge clk); #2;
    check("t2_release_pops", n_pop - p0, 4);
    repeat (6) tick(0, '0, 0);

    // Redirect with responses both buffered and in flight
    lat_lo = 4; lat_hi = 4;
    fired = 1'b0;
    for (int i = 0; i < 30 && !fired; i++) begin
      tick(0, '0, 1);
      @(negedge clk); #2;
      fired = (m_fifo >= 2) && (cred_now() >= 1);
    end
    if (!fired) begin
      total++; bad++;
      $display("FAIL t3_setup: buffered=%0d inflight=%0d, want >=2 and >=1", m_fifo, cred_now());
    end
    tick(1, 32'h0000_0100, 1);
    tick(0, '0, 0);
    check("t3_cleared", instr_valid, 0);
    settle_mark(p);
    wait_pop(p, "t3_first", 32'h0000_0100);

    // Redirect landing on a response beat, unaligned target
    lat_lo = 1; lat_hi = 2;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) tick_rof(32'h0000_0203, fired);
    if (!fired) begin
      total++; bad++;
      $display("FAIL t4_setup: no response beat to redirect on");
    end
    settle_mark(p);
    wait_pop(p, "t4_first", 32'h0000_0200);

    // Back-to-back redirects
    tick(1, 32'h0000_0040, 0);
    tick(1, 32'h0000_0080, 0);
    settle_mark(p);
    wait_pop(p, "t5_first", 32'h0000_0080);

    // Reset in the middle of traffic
    lat_lo = 3; lat_hi = 3;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      tick(0, '0, 0);
      @(negedge clk); #2;
      fired = cred_now() >= 3;
    end
    if (!fired) begin
      total++; bad++;
      $display("FAIL t6_setup: inflight=%0d, want >=3", cred_now());
    end
    mid_reset();
    settle_mark(p);
    wait_pop(p, "t6_first", 32'h8000_0000);

    // Random traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 32) == 0, $urandom, ($urandom % 10) < 3);
    end
    tick(0, '0, 0);
    @(negedge clk); #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
